sram_bist_master: RTL

- Wishbone classic master that runs a March-style built-in self test on the SRAM_1024x32 user macro.
- Sits directly upstream of the SRAM. Its master port drives the SRAM's Wishbone slave port through the wrapper mux.
- Start, pattern and results are carried on logic-analyzer bits.
- Reports pass/fail, first failing word address, read data and a bus-timeout flag.

---
 rtl/sram_bist_master.sv | 352 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_bist_master.sv
// sram_bist_master: Wishbone classic master that runs a March-style self test
// (W(P) up; R(P),W(~P) up; R(~P),W(P) down; R(P) up) on a 32-bit SRAM.
//
// Optional feature macro: SRAM_BIST_ERR_CNT_EN
//   defined   : mismatches are counted (saturating) and the run continues
//   undefined : err_count_o is tied to 0 and the first mismatch ends the run
//
// Ports:
//   wb_clk_i, wb_rst_ni       clock / async active-low reset
//   start_i, abort_i          run control (levels)
//   pattern_i                 data background, latched at start
//   busy_o, done_o, pass_o    run status
//   timeout_o                 run ended on an ack timeout
//   fail_addr_o, fail_data_o  first failing word index and data read there
//   err_count_o               mismatch count
//   m_*                       Wishbone classic master port
module sram_bist_master #(
    parameter int unsigned ADDR_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] pattern_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        timeout_o,
    output logic [9:0]  fail_addr_o,
    output logic [31:0] fail_data_o,
    output logic [15:0] err_count_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic        m_ack_i,
    input  logic [31:0] m_dat_i
);

    localparam int unsigned IDX_W = 10;
    localparam int unsigned TO_W  = 8;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned DW    = 32;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ADDR_WORDS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DONE,
        S_REQ,
        S_WAIT,
        S_GAP
    } state_e;

    // Element 3 is read-only, elements 1/2 read on phase 0 and write on phase 1.
    function automatic logic op_is_read(input logic [1:0] e, input logic ph);
        return (e == 2'd3) || (((e == 2'd1) || (e == 2'd2)) && !ph);
    endfunction

    // Operations whose data is the inverted background.
    function automatic logic op_inv(input logic [1:0] e, input logic ph);
        return ((e == 2'd1) && ph) || ((e == 2'd2) && !ph);
    endfunction

    state_e            state_q, state_d;
    logic [1:0]        elem_q, elem_d;
    logic              ph_q, ph_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DW-1:0]     pat_q, pat_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              abort_pend_q, abort_pend_d;
    logic              fin_q, fin_d;
    logic              fail_seen_q, fail_seen_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic [IDX_W-1:0]  fail_addr_q, fail_addr_d;
    logic [DW-1:0]     fail_data_q, fail_data_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [DW-1:0]     adr_q, adr_d;
    logic [DW-1:0]     dat_q, dat_d;

    logic              launch;
    logic              drop_bus;
    logic              rd_op;
    logic [DW-1:0]     exp_data;

    // Next-state, sequencing, compare and bus-output logic
    always_comb begin
        state_d      = state_q;
        elem_d       = elem_q;
        ph_d         = ph_q;
        idx_d        = idx_q;
        pat_d        = pat_q;
        to_cnt_d     = to_cnt_q;
        abort_pend_d = abort_pend_q;
        fin_d        = fin_q;
        fail_seen_d  = fail_seen_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        fail_addr_d  = fail_addr_q;
        fail_data_d  = fail_data_q;
        err_cnt_d    = err_cnt_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        we_d         = we_q;
        sel_d        = sel_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        launch       = 1'b0;
        drop_bus     = 1'b0;
        rd_op        = op_is_read(elem_q, ph_q);
        exp_data     = op_inv(elem_q, ph_q) ? ~pat_q : pat_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i && !abort_i) begin
                    pat_d        = pattern_i;
                    elem_d       = 2'd0;
                    ph_d         = 1'b0;
                    idx_d        = '0;
                    to_cnt_d     = '0;
                    abort_pend_d = 1'b0;
                    fin_d        = 1'b0;
                    fail_seen_d  = 1'b0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    timeout_d    = 1'b0;
                    fail_addr_d  = '0;
                    fail_data_d  = '0;
                    err_cnt_d    = '0;
                    state_d      = S_REQ;
                    launch       = 1'b1;
                end
            end

            S_REQ: begin
                if (abort_i) begin
                    drop_bus = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                // An abort here is remembered and honoured once the handshake closes.
                if (abort_i) begin
                    abort_pend_d = 1'b1;
                end
                if (m_ack_i) begin
                    drop_bus = 1'b1;
                    to_cnt_d = '0;
                    state_d  = S_GAP;
                    if (rd_op && (m_dat_i != exp_data)) begin
                        if (!fail_seen_q) begin
                            fail_seen_d = 1'b1;
                            fail_addr_d = idx_q;
                            fail_data_d = m_dat_i;
                        end
`ifdef SRAM_BIST_ERR_CNT_EN
                        if (err_cnt_q != {CNT_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
`endif
                    end
                    // Advance to the next operation of the march sequence.
                    unique case (elem_q)
                        2'd0: begin
                            if (idx_q == IDX_LAST) begin
                                elem_d = 2'd1;
                                idx_d  = '0;
                            end else begin
                                idx_d = idx_q + IDX_W'(1);
                            end
                        end
                        2'd1: begin
                            ph_d = !ph_q;
                            if (ph_q) begin
                                if (idx_q == IDX_LAST) begin
                                    elem_d = 2'd2;
                                    idx_d  = IDX_LAST;
                                end else begin
                                    idx_d = idx_q + IDX_W'(1);
                                end
                            end
                        end
                        2'd2: begin
                            ph_d = !ph_q;
                            if (ph_q) begin
                                if (idx_q == '0) begin
                                    elem_d = 2'd3;
                                end else begin
                                    idx_d = idx_q - IDX_W'(1);
                                end
                            end
                        end
                        default: begin
                            if (idx_q == IDX_LAST) begin
                                fin_d = 1'b1;
                            end else begin
                                idx_d = idx_q + IDX_W'(1);
                            end
                        end
                    endcase
                end else if (to_cnt_q == TO_LAST) begin
                    drop_bus    = 1'b1;
                    busy_d      = 1'b0;
                    timeout_d   = 1'b1;
                    pass_d      = 1'b0;
                    fail_addr_d = idx_q;
                    to_cnt_d    = '0;
                    if (abort_i || abort_pend_q) begin
                        state_d = S_IDLE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            S_GAP: begin
                if (abort_i || abort_pend_q) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
`ifdef SRAM_BIST_ERR_CNT_EN
                end else if (fin_q) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_q == '0) && !timeout_q;
                    state_d = S_DONE;
`else
                end else if (fin_q || fail_seen_q) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = !fail_seen_q;
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_REQ;
                    launch  = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (drop_bus) begin
            cyc_d = 1'b0;
            stb_d = 1'b0;
            we_d  = 1'b0;
            sel_d = 4'h0;
            adr_d = '0;
            dat_d = '0;
        end
        // Bus fields come from the operation being entered, already sequenced.
        if (launch) begin
            cyc_d = 1'b1;
            stb_d = 1'b1;
            sel_d = 4'hF;
            we_d  = !op_is_read(elem_d, ph_d);
            adr_d = BASE_ADDR + DW'({idx_d, 2'b00});
            dat_d = op_is_read(elem_d, ph_d) ? '0 :
                    (op_inv(elem_d, ph_d) ? ~pat_d : pat_d);
        end
    end

    // State and output registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q      <= S_IDLE;
            elem_q       <= 2'd0;
            ph_q         <= 1'b0;
            idx_q        <= '0;
            pat_q        <= '0;
            to_cnt_q     <= '0;
            abort_pend_q <= 1'b0;
            fin_q        <= 1'b0;
            fail_seen_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            fail_addr_q  <= '0;
            fail_data_q  <= '0;
            err_cnt_q    <= '0;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            sel_q        <= 4'h0;
            adr_q        <= '0;
            dat_q        <= '0;
        end else begin
            state_q      <= state_d;
            elem_q       <= elem_d;
            ph_q         <= ph_d;
            idx_q        <= idx_d;
            pat_q        <= pat_d;
            to_cnt_q     <= to_cnt_d;
            abort_pend_q <= abort_pend_d;
            fin_q        <= fin_d;
            fail_seen_q  <= fail_seen_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            fail_addr_q  <= fail_addr_d;
            fail_data_q  <= fail_data_d;
            err_cnt_q    <= err_cnt_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign timeout_o   = timeout_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_data_o = fail_data_q;
    assign err_count_o = err_cnt_q;
    assign m_cyc_o     = cyc_q;
    assign m_stb_o     = stb_q;
    assign m_we_o      = we_q;
    assign m_sel_o     = sel_q;
    assign m_adr_o     = adr_q;
    assign m_dat_o     = dat_q;

endmodule
